// File: rtl/fsx_timing.sv
// Raster timing generator with a priority layer compositor for a VGA/CRT output.
// Sync and enable are delayed so they line up with the registered pixel colour.
module fsx_timing #(
  parameter int unsigned H_RES       = 320,
  parameter int unsigned V_RES       = 240,
  parameter int unsigned H_FP        = 23,
  parameter int unsigned H_SYNC      = 28,
  parameter int unsigned H_BP        = 45,
  parameter int unsigned V_FP        = 6,
  parameter int unsigned V_SYNC      = 3,
  parameter int unsigned V_BP        = 20,
  parameter bit          H_POL       = 1'b0,
  parameter bit          V_POL       = 1'b0,
  parameter int unsigned LAYERS      = 2,
  parameter int unsigned PIPE        = 2,
  parameter int unsigned FRAME_PULSE = 8
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic [8*LAYERS-1:0]   layer_rgb,
  input  logic [LAYERS-1:0]     layer_valid,
  input  logic [7:0]            bg_color,
  output logic [9:0]            h_count,
  output logic [8:0]            v_count,
  output logic                  o_de,
  output logic [9:0]            o_h,
  output logic [8:0]            o_v,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_de,
  output logic                  crt_sync,
  output logic [2:0]            crt_r,
  output logic [2:0]            crt_g,
  output logic [1:0]            crt_b,
  output logic                  frameDrawn
);

  localparam int unsigned H_TOT = H_FP + H_SYNC + H_BP + H_RES;
  localparam int unsigned V_TOT = V_FP + V_SYNC + V_BP + V_RES;
  localparam int unsigned H_ACT = H_TOT - H_RES;
  localparam int unsigned V_ACT = V_TOT - V_RES;
  localparam int unsigned SW    = 3 * (PIPE + 1);

  logic [9:0]    h_q, h_d;
  logic [8:0]    v_q, v_d;
  logic          hs_raw, vs_raw;
  logic [SW-1:0] sync_q, sync_d;
  logic          de_pre;
  logic [7:0]    pix;
  logic [7:0]    rgb_q, rgb_d;
  logic          fd_q, fd_d;

  // Raster counters
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'(H_TOT - 1)) begin
      h_d = '0;
      v_d = (v_q == 9'(V_TOT - 1)) ? '0 : v_q + 9'd1;
    end
  end

  // Raw timing decode; sync flags are kept in asserted-high form internally
  always_comb begin
    hs_raw = (h_q >= 10'(H_FP)) && (h_q < 10'(H_FP + H_SYNC));
    vs_raw = (v_q >= 9'(V_FP)) && (v_q < 9'(V_FP + V_SYNC));
    o_de   = (h_q >= 10'(H_ACT)) && (v_q >= 9'(V_ACT));
    o_h    = o_de ? h_q - 10'(H_ACT) : '0;
    o_v    = o_de ? v_q - 9'(V_ACT) : '0;
  end

  // Delay line of {hs,vs,de} triples; the top triple feeds the outputs
  always_comb begin
    sync_d = SW'({sync_q, hs_raw, vs_raw, o_de});
    de_pre = sync_d[SW-3];
  end

  // Highest-index opaque layer wins, background otherwise
  always_comb begin
    pix = bg_color;
    for (int k = 0; k < LAYERS; k++) begin
      if (layer_valid[k]) pix = layer_rgb[8*k +: 8];
    end
    rgb_d = de_pre ? pix : '0;
    fd_d  = (v_q == '0) && (h_q < 10'(FRAME_PULSE));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q    <= '0;
      v_q    <= '0;
      sync_q <= '0;
      rgb_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      sync_q <= sync_d;
      rgb_q  <= rgb_d;
      fd_q   <= fd_d;
    end
  end

  assign h_count    = h_q;
  assign v_count    = v_q;
  assign vga_hs     = sync_q[SW-1] ? H_POL : ~H_POL;
  assign vga_vs     = sync_q[SW-2] ? V_POL : ~V_POL;
  assign vga_de     = sync_q[SW-3];
  assign crt_sync   = ~(vga_hs ^ vga_vs);
  assign crt_r      = rgb_q[7:5];
  assign crt_g      = rgb_q[4:2];
  assign crt_b      = rgb_q[1:0];
  assign frameDrawn = fd_q;

endmodule

// File: tb/tb_fsx_timing.sv
// Scoreboard bench: two small-raster instances checked every cycle against a
// history-based model, plus directed checks on a default-parameter instance.
module tb_fsx_timing;

  localparam int HR = 16, HFP = 3, HSY = 4, HBP = 5;
  localparam int VR = 6,  VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HR + HFP + HSY + HBP;   // 28
  localparam int VT = VR + VFP + VSY + VBP;   // 13
  localparam int FPW = 3;

  typedef struct packed {
    logic       hs, vs, de, fd;
    logic [7:0] pick2, pick1;
  } hist_t;

  typedef struct packed {
    logic [9:0] h;
    logic [8:0] v;
    logic       de;
    logic [9:0] oh;
    logic [8:0] ov;
    logic       hs, vs, vde, csync;
    logic [7:0] rgb;
    logic       fd;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rst_d_n = 1'b0;
  logic [15:0] layer_rgb = '0;
  logic [1:0]  layer_valid = '0;
  logic [7:0]  bg_color = '0;

  int n_chk = 0;
  int n_fail = 0;
  bit done_d = 1'b0;
  hist_t hist[$];
  exp_t  exp_q[$];
  int    c = 0;

  always #5 clk = ~clk;

  // Instance A: two layers, PIPE=2, active-low hsync, active-high vsync
  logic [9:0] a_h, a_oh; logic [8:0] a_v, a_ov;
  logic a_de, a_hs, a_vs, a_vde, a_cs, a_fd;
  logic [2:0] a_r, a_g; logic [1:0] a_b;
  fsx_timing #(.H_RES(HR), .V_RES(VR), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
               .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .H_POL(1'b0), .V_POL(1'b1),
               .LAYERS(2), .PIPE(2), .FRAME_PULSE(FPW)) dut (
    .vga_clk(clk), .reset_n(reset_n), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
    .bg_color(bg_color), .h_count(a_h), .v_count(a_v), .o_de(a_de), .o_h(a_oh), .o_v(a_ov),
    .vga_hs(a_hs), .vga_vs(a_vs), .vga_de(a_vde), .crt_sync(a_cs),
    .crt_r(a_r), .crt_g(a_g), .crt_b(a_b), .frameDrawn(a_fd));

  // Instance B: single layer, PIPE=0, opposite polarities
  logic [9:0] b_h, b_oh; logic [8:0] b_v, b_ov;
  logic b_de, b_hs, b_vs, b_vde, b_cs, b_fd;
  logic [2:0] b_r, b_g; logic [1:0] b_b;
  fsx_timing #(.H_RES(HR), .V_RES(VR), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
               .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .H_POL(1'b1), .V_POL(1'b0),
               .LAYERS(1), .PIPE(0), .FRAME_PULSE(FPW)) dut1 (
    .vga_clk(clk), .reset_n(reset_n), .layer_rgb(layer_rgb[7:0]), .layer_valid(layer_valid[0]),
    .bg_color(bg_color), .h_count(b_h), .v_count(b_v), .o_de(b_de), .o_h(b_oh), .o_v(b_ov),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_vde), .crt_sync(b_cs),
    .crt_r(b_r), .crt_g(b_g), .crt_b(b_b), .frameDrawn(b_fd));

  // Instance D: all default parameters
  logic [9:0] d_h, d_oh; logic [8:0] d_v, d_ov;
  logic d_de, d_hs, d_vs, d_vde, d_cs, d_fd;
  logic [2:0] d_r, d_g; logic [1:0] d_b;
  fsx_timing dut_d (
    .vga_clk(clk), .reset_n(rst_d_n), .layer_rgb(16'hE01C), .layer_valid(2'b11),
    .bg_color(8'h03), .h_count(d_h), .v_count(d_v), .o_de(d_de), .o_h(d_oh), .o_v(d_ov),
    .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_vde), .crt_sync(d_cs),
    .crt_r(d_r), .crt_g(d_g), .crt_b(d_b), .frameDrawn(d_fd));

  obs_t act_a, act_b;
  assign act_a = {a_h, a_v, a_de, a_oh, a_ov, a_hs, a_vs, a_vde, a_cs, a_r, a_g, a_b, a_fd};
  assign act_b = {b_h, b_v, b_de, b_oh, b_ov, b_hs, b_vs, b_vde, b_cs, b_r, b_g, b_b, b_fd};

  // Expected outputs in interval c, from what was driven in earlier intervals
  function automatic obs_t model(int cc, int p, bit hpol, bit vpol, bit one_layer);
    obs_t  o;
    hist_t al;
    int h, v;
    h = cc % HT;
    v = (cc / HT) % VT;
    o = '0;
    o.h  = 10'(h);
    o.v  = 9'(v);
    o.de = (h >= HT - HR) && (v >= VT - VR);
    o.oh = o.de ? 10'(h - (HT - HR)) : 10'd0;
    o.ov = o.de ? 9'(v - (VT - VR)) : 9'd0;
    al = '0;
    if (cc - p - 1 >= 0) al = hist[cc - p - 1];
    o.hs    = al.hs ? hpol : !hpol;
    o.vs    = al.vs ? vpol : !vpol;
    o.vde   = al.de;
    o.csync = !(o.hs ^ o.vs);
    if (al.de && cc >= 1) o.rgb = one_layer ? hist[cc - 1].pick1 : hist[cc - 1].pick2;
    o.fd = (cc >= 1) ? hist[cc - 1].fd : 1'b0;
    return o;
  endfunction

  task automatic chk_obs(string nm, obs_t act, obs_t expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, expv);
    end
  endtask

  task automatic chk_val(string nm, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, expv);
    end
  endtask

  // One interval: drive inputs, queue the expectation, record history
  task automatic step(input bit rst);
    exp_t  e;
    hist_t r;
    int h, v, idx;
    @(posedge clk);
    #1;
    if (rst) begin
      reset_n = 1'b0;
      hist.delete();
      c = 0;
    end else begin
      reset_n = 1'b1;
    end
    e.a = model(c, 2, 1'b0, 1'b1, 1'b0);
    e.b = model(c, 0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(e);
    if (rst) return;
    idx = (c / 5) % 5;
    case (idx)
      0: begin layer_rgb = 16'hE01C; layer_valid = 2'b11; bg_color = 8'h00; end
      1: begin layer_rgb = 16'hE01C; layer_valid = 2'b01; bg_color = 8'h00; end
      2: begin layer_rgb = 16'hE01C; layer_valid = 2'b00; bg_color = 8'h03; end
      3: begin layer_rgb = 16'h1CE0; layer_valid = 2'b10; bg_color = 8'h55; end
      default: begin layer_rgb = 16'h1CE0; layer_valid = 2'b00; bg_color = 8'hFF; end
    endcase
    h = c % HT;
    v = (c / HT) % VT;
    r.hs    = (h >= HFP) && (h < HFP + HSY);
    r.vs    = (v >= VFP) && (v < VFP + VSY);
    r.de    = (h >= HT - HR) && (v >= VT - VR);
    r.fd    = (v == 0) && (h < FPW);
    r.pick1 = layer_valid[0] ? layer_rgb[7:0] : bg_color;
    r.pick2 = layer_valid[1] ? layer_rgb[15:8] : r.pick1;
    hist.push_back(r);
    c++;
  endtask

  // Monitor: compare both instances whenever an expectation is pending
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_obs("dutA", act_a, e.a);
        chk_obs("dutB", act_b, e.b);
      end
    end
  end

  // Directed checks on the default-parameter instance
  initial begin
    int cd;
    #26 rst_d_n = 1'b1;
    cd = 0;
    while (cd <= 12485) begin
      @(negedge clk);
      case (cd)
        0: begin
          chk_val("d_h0", 32'(d_h), 32'd0);
          chk_val("d_sync_idle", 32'({d_hs, d_vs, d_cs, d_vde, d_fd}), 32'b11100);
        end
        1: begin
          chk_val("d_h1", 32'(d_h), 32'd1);
          chk_val("d_fd_first", 32'(d_fd), 32'd1);
        end
        8:     chk_val("d_fd_last", 32'(d_fd), 32'd1);
        9:     chk_val("d_fd_off", 32'(d_fd), 32'd0);
        25:    chk_val("d_hs_pre", 32'(d_hs), 32'd1);
        26:    chk_val("d_hs_start", 32'(d_hs), 32'd0);
        53:    chk_val("d_hs_end", 32'(d_hs), 32'd0);
        54:    chk_val("d_hs_post", 32'(d_hs), 32'd1);
        12159: chk_val("d_de_before", 32'(d_de), 32'd0);
        12160: begin
          chk_val("d_first_pos", 32'({d_v, d_h}), 32'({9'd29, 10'd96}));
          chk_val("d_first_px", 32'({d_de, d_ov, d_oh}), 32'd1 << 19);
        end
        12162: chk_val("d_vde_pre", 32'(d_vde), 32'd0);
        12163: begin
          chk_val("d_vde_first", 32'(d_vde), 32'd1);
          chk_val("d_rgb_first", 32'({d_r, d_g, d_b}), 32'hE0);
        end
        12479: chk_val("d_last_x", 32'({d_de, d_oh}), 32'({1'b1, 10'd319}));
        12480: chk_val("d_de_off", 32'(d_de), 32'd0);
        default: ;
      endcase
      cd++;
    end
    done_d = 1'b1;
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 1000; i++) step(1'b0);
    // Asynchronous reset mid-line, mid-frame
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 11600; i++) step(1'b0);
    @(negedge clk);
    #1;
    chk_val("queue_drained", 32'(exp_q.size()), 32'd0);
    chk_val("default_checks_done", 32'(done_d), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
